// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single txs/txe RAM port.
// Request fields are latched at grant; a per-transaction timeout turns a hung RAM into an error completion.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_txs,
  input  logic        m0_re,
  input  logic        m0_we,
  input  logic [63:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_txe,
  output logic        m0_err,
  output logic [31:0] m0_rd,
  input  logic        m1_txs,
  input  logic        m1_re,
  input  logic        m1_we,
  input  logic [63:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_txe,
  output logic        m1_err,
  output logic [31:0] m1_rd,
  output logic        ram_txs,
  output logic        ram_re,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [31:0] ram_wd,
  input  logic        ram_txe,
  input  logic        ram_err,
  input  logic [31:0] ram_out,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic        r_rr_m1;

  logic        w_pick_m1;
  logic        w_grant_any;
  logic        w_timeout;
  logic        w_owner_txs;
  logic        w_release;
  logic        w_res_done;
  logic        w_res_err;
  logic [31:0] w_res_rd;

  logic        w_ram_txs_n, w_ram_re_n, w_ram_we_n;
  logic [63:0] w_ram_addr_n;
  logic [31:0] w_ram_wd_n;
  logic [1:0]  w_grant_n;
  logic        w_m0_txe_n, w_m0_err_n, w_m1_txe_n, w_m1_err_n;
  logic [31:0] w_m0_rd_n, w_m1_rd_n;
  logic [31:0] w_cnt_n;
  logic        w_rr_n;

  // r_rr_m1 set means m1 wins the next tie (m0 was served last)
  assign w_pick_m1   = m1_txs & (~m0_txs | r_rr_m1);
  assign w_grant_any = (m0_txs | m1_txs) & ~ram_txe;
  assign w_timeout   = (r_cnt >= TIMEOUT);
  assign w_owner_txs = grant[1] ? m1_txs : m0_txs;
  assign w_release   = ~w_owner_txs & ~ram_txe;

  // State, output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 32'd0;
      r_rr_m1  <= 1'b0;
      ram_txs  <= 1'b0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= 64'd0;
      ram_wd   <= 32'd0;
      grant    <= 2'b00;
      m0_txe   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rd    <= 32'd0;
      m1_txe   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rd    <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_n;
      r_rr_m1  <= w_rr_n;
      ram_txs  <= w_ram_txs_n;
      ram_re   <= w_ram_re_n;
      ram_we   <= w_ram_we_n;
      ram_addr <= w_ram_addr_n;
      ram_wd   <= w_ram_wd_n;
      grant    <= w_grant_n;
      m0_txe   <= w_m0_txe_n;
      m0_err   <= w_m0_err_n;
      m0_rd    <= w_m0_rd_n;
      m1_txe   <= w_m1_txe_n;
      m1_err   <= w_m1_err_n;
      m1_rd    <= w_m1_rd_n;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_grant_any ? S_ISSUE : S_IDLE;
      S_ISSUE: w_state_nxt = (ram_txe | w_timeout) ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nxt = w_release ? S_IDLE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ram_txs_n  = ram_txs;
    w_ram_re_n   = ram_re;
    w_ram_we_n   = ram_we;
    w_ram_addr_n = ram_addr;
    w_ram_wd_n   = ram_wd;
    w_grant_n    = grant;
    w_m0_txe_n   = m0_txe;
    w_m0_err_n   = m0_err;
    w_m0_rd_n    = m0_rd;
    w_m1_txe_n   = m1_txe;
    w_m1_err_n   = m1_err;
    w_m1_rd_n    = m1_rd;
    w_cnt_n      = r_cnt;
    w_rr_n       = r_rr_m1;
    w_res_done   = 1'b0;
    w_res_err    = 1'b0;
    w_res_rd     = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_ram_txs_n  = 1'b1;
          w_ram_re_n   = w_pick_m1 ? m1_re   : m0_re;
          w_ram_we_n   = w_pick_m1 ? m1_we   : m0_we;
          w_ram_addr_n = w_pick_m1 ? m1_addr : m0_addr;
          w_ram_wd_n   = w_pick_m1 ? m1_wd   : m0_wd;
          w_grant_n    = w_pick_m1 ? 2'b10   : 2'b01;
          w_cnt_n      = 32'd0;
        end else begin
          w_grant_n    = 2'b00;
        end
      end
      S_ISSUE: begin
        // A real completion takes priority over a timeout in the same cycle
        if (ram_txe) begin
          w_res_done = 1'b1;
          w_res_err  = ram_err;
          w_res_rd   = ram_re ? ram_out : 32'd0;
        end else if (w_timeout) begin
          w_res_done = 1'b1;
          w_res_err  = 1'b1;
          w_res_rd   = 32'd0;
        end else begin
          w_cnt_n    = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
        end
        if (w_res_done) begin
          w_ram_txs_n = 1'b0;
          w_ram_re_n  = 1'b0;
          w_ram_we_n  = 1'b0;
          w_rr_n      = grant[0];
          w_m0_txe_n  = grant[0];
          w_m0_err_n  = grant[0] & w_res_err;
          w_m0_rd_n   = grant[0] ? w_res_rd : 32'd0;
          w_m1_txe_n  = grant[1];
          w_m1_err_n  = grant[1] & w_res_err;
          w_m1_rd_n   = grant[1] ? w_res_rd : 32'd0;
        end else begin
          w_rr_n      = r_rr_m1;
        end
      end
      S_DONE: begin
        if (w_release) begin
          w_grant_n  = 2'b00;
          w_m0_txe_n = 1'b0;
          w_m0_err_n = 1'b0;
          w_m0_rd_n  = 32'd0;
          w_m1_txe_n = 1'b0;
          w_m1_err_n = 1'b0;
          w_m1_rd_n  = 32'd0;
        end else begin
          w_grant_n  = grant;
        end
      end
      default: begin
        w_ram_txs_n = 1'b0;
        w_grant_n   = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter, built with TIMEOUT=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_txs, m0_re, m0_we;
  logic [63:0] m0_addr;
  logic [31:0] m0_wd;
  logic        m0_txe, m0_err;
  logic [31:0] m0_rd;
  logic        m1_txs, m1_re, m1_we;
  logic [63:0] m1_addr;
  logic [31:0] m1_wd;
  logic        m1_txe, m1_err;
  logic [31:0] m1_rd;
  logic        ram_txs, ram_re, ram_we;
  logic [63:0] ram_addr;
  logic [31:0] ram_wd;
  logic        ram_txe, ram_err;
  logic [31:0] ram_out;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT(32'd8)) dut (
    .clk(clk), .rst(rst),
    .m0_txs(m0_txs), .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_txe(m0_txe), .m0_err(m0_err), .m0_rd(m0_rd),
    .m1_txs(m1_txs), .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_txe(m1_txe), .m1_err(m1_err), .m1_rd(m1_rd),
    .ram_txs(ram_txs), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_txe(ram_txe), .ram_err(ram_err), .ram_out(ram_out),
    .grant(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_txs = 1'b0; m0_re = 1'b0; m0_we = 1'b0; m0_addr = 64'd0; m0_wd = 32'd0;
    m1_txs = 1'b0; m1_re = 1'b0; m1_we = 1'b0; m1_addr = 64'd0; m1_wd = 32'd0;
    ram_txe = 1'b0; ram_err = 1'b0; ram_out = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, ram_txs, ram_re, ram_we, m0_txe, m0_err, m1_txe, m1_err} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b exp 0", {grant, ram_txs, ram_re, ram_we, m0_txe, m0_err, m1_txe, m1_err});
    end
    n_checks++;
    if ({ram_addr, ram_wd, m0_rd, m1_rd} !== 160'd0) begin
      n_errors++;
      $display("FAIL reset_data got %h exp 0", {ram_addr, ram_wd, m0_rd, m1_rd});
    end
  endtask

  task automatic test_m0_read();
    do_reset();
    m0_txs = 1'b1; m0_re = 1'b1; m0_addr = 64'h10;
    tick();
    n_checks++;
    if ({grant, ram_txs, ram_re, ram_we} !== 5'b01_1_1_0) begin
      n_errors++;
      $display("FAIL rd_grant got %b exp 01110", {grant, ram_txs, ram_re, ram_we});
    end
    n_checks++;
    if (ram_addr !== 64'h10) begin
      n_errors++;
      $display("FAIL rd_addr got %h exp 10", ram_addr);
    end
    tick();
    tick();
    n_checks++;
    if ({m0_txe, m1_txe, ram_txs} !== 3'b001) begin
      n_errors++;
      $display("FAIL rd_wait got %b exp 001", {m0_txe, m1_txe, ram_txs});
    end
    ram_txe = 1'b1; ram_out = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({m0_txe, m0_err, m1_txe, ram_txs, ram_re} !== 5'b10000) begin
      n_errors++;
      $display("FAIL rd_done got %b exp 10000", {m0_txe, m0_err, m1_txe, ram_txs, ram_re});
    end
    n_checks++;
    if (m0_rd !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL rd_data got %h exp deadbeef", m0_rd);
    end
    ram_txe = 1'b0; ram_out = 32'd0; m0_txs = 1'b0;
    tick();
    n_checks++;
    if ({grant, m0_txe, m1_txe} !== 4'b0000 || m0_rd !== 32'd0) begin
      n_errors++;
      $display("FAIL rd_release got grant=%b txe=%b%b rd=%h exp 00 00 0", grant, m0_txe, m1_txe, m0_rd);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    m0_re = 1'b1; m0_addr = 64'h100; m0_wd = 32'd0;
    m1_we = 1'b1; m1_addr = 64'h20; m1_wd = 32'h55AA;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      m0_txs = 1'b1; m1_txs = 1'b1;
      tick();
      n_checks++;
      if (grant !== exp_g) begin
        n_errors++;
        $display("FAIL rr_grant%0d got %b exp %b", i, grant, exp_g);
      end
      n_checks++;
      if (exp_g == 2'b10 && (ram_addr !== 64'h20 || ram_wd !== 32'h55AA || ram_we !== 1'b1 || ram_re !== 1'b0)) begin
        n_errors++;
        $display("FAIL rr_m1fields%0d got a=%h wd=%h we=%b re=%b exp 20 55aa 1 0", i, ram_addr, ram_wd, ram_we, ram_re);
      end else if (exp_g == 2'b01 && (ram_addr !== 64'h100 || ram_wd !== 32'd0 || ram_we !== 1'b0 || ram_re !== 1'b1)) begin
        n_errors++;
        $display("FAIL rr_m0fields%0d got a=%h wd=%h we=%b re=%b exp 100 0 0 1", i, ram_addr, ram_wd, ram_we, ram_re);
      end
      ram_txe = 1'b1; ram_out = 32'h1000 + i;
      tick();
      n_checks++;
      if (exp_g == 2'b01 && ({m0_txe, m1_txe} !== 2'b10 || m0_rd !== 32'h1000 + i)) begin
        n_errors++;
        $display("FAIL rr_done%0d got txe=%b%b rd=%h exp 10 %h", i, m0_txe, m1_txe, m0_rd, 32'h1000 + i);
      end else if (exp_g == 2'b10 && ({m0_txe, m1_txe} !== 2'b01 || m1_rd !== 32'd0)) begin
        n_errors++;
        $display("FAIL rr_done%0d got txe=%b%b rd=%h exp 01 0", i, m0_txe, m1_txe, m1_rd);
      end
      ram_txe = 1'b0; ram_out = 32'd0;
      if (exp_g == 2'b01) m0_txs = 1'b0;
      else m1_txs = 1'b0;
      tick();
      n_checks++;
      if (grant !== 2'b00) begin
        n_errors++;
        $display("FAIL rr_release%0d got %b exp 00", i, grant);
      end
    end
    m0_txs = 1'b0; m1_txs = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_txs = 1'b1; m0_re = 1'b1; m0_addr = 64'h30;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if ({m0_txe, ram_txs} !== 2'b01) begin
        n_errors++;
        $display("FAIL to_wait%0d got %b exp 01", k, {m0_txe, ram_txs});
      end
    end
    tick();
    n_checks++;
    if ({m0_txe, m0_err, ram_txs, ram_re} !== 4'b1100 || m0_rd !== 32'd0) begin
      n_errors++;
      $display("FAIL to_abort got %b rd=%h exp 1100 0", {m0_txe, m0_err, ram_txs, ram_re}, m0_rd);
    end
    m0_txs = 1'b0;
    tick();
    m0_txs = 1'b1;
    tick();
    n_checks++;
    if ({grant, ram_txs} !== 3'b011) begin
      n_errors++;
      $display("FAIL to_regrant got %b exp 011", {grant, ram_txs});
    end
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0; m0_txs = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_txs = 1'b1; m0_re = 1'b1; m0_addr = 64'h40;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    ram_txe = 1'b1; ram_err = 1'b0; ram_out = 32'hCAFEF00D;
    tick();
    n_checks++;
    if ({m0_txe, m0_err} !== 2'b10 || m0_rd !== 32'hCAFEF00D) begin
      n_errors++;
      $display("FAIL sim_done got txe=%b err=%b rd=%h exp 1 0 cafef00d", m0_txe, m0_err, m0_rd);
    end
    ram_txe = 1'b0; ram_out = 32'd0; m0_txs = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_txs = 1'b1; m0_re = 1'b1; m0_addr = 64'h50;
    m1_we = 1'b1; m1_addr = 64'h60; m1_wd = 32'h77;
    tick();
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0; m0_txs = 1'b0;
    tick();
    m0_txs = 1'b1; m1_txs = 1'b1;
    tick();
    n_checks++;
    if (grant !== 2'b10) begin
      n_errors++;
      $display("FAIL rm_pre got %b exp 10", grant);
    end
    rst = 1'b1; ram_txe = 1'b1;
    tick();
    n_checks++;
    if ({grant, ram_txs, ram_we, m0_txe, m1_txe, m1_err} !== 7'd0) begin
      n_errors++;
      $display("FAIL rm_cleared got %b exp 0", {grant, ram_txs, ram_we, m0_txe, m1_txe, m1_err});
    end
    rst = 1'b0; ram_txe = 1'b0;
    tick();
    n_checks++;
    if (grant !== 2'b01) begin
      n_errors++;
      $display("FAIL rm_tie got %b exp 01", grant);
    end
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0; m0_txs = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({grant, ram_we, ram_addr} !== {2'b10, 1'b1, 64'h60}) begin
      n_errors++;
      $display("FAIL rm_m1 got g=%b we=%b a=%h exp 10 1 60", grant, ram_we, ram_addr);
    end
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0; m1_txs = 1'b0;
    tick();
  endtask

  task automatic test_err_write();
    do_reset();
    m1_txs = 1'b1; m1_we = 1'b1; m1_addr = 64'h20; m1_wd = 32'h55AA;
    tick();
    ram_txe = 1'b1; ram_err = 1'b1; ram_out = 32'hFFFF;
    tick();
    n_checks++;
    if ({m1_txe, m1_err, m0_txe, m0_err} !== 4'b1100 || m1_rd !== 32'd0) begin
      n_errors++;
      $display("FAIL ew_done got %b rd=%h exp 1100 0", {m1_txe, m1_err, m0_txe, m0_err}, m1_rd);
    end
    m0_txs = 1'b1;
    tick();
    n_checks++;
    if ({m1_txe, m1_err, grant} !== 4'b1110) begin
      n_errors++;
      $display("FAIL ew_hold got %b exp 1110", {m1_txe, m1_err, grant});
    end
    m1_txs = 1'b0;
    tick();
    n_checks++;
    if ({m1_txe, grant, m0_txe} !== 4'b1100) begin
      n_errors++;
      $display("FAIL ew_txe_high got %b exp 1100", {m1_txe, grant, m0_txe});
    end
    ram_txe = 1'b0; ram_err = 1'b0;
    tick();
    n_checks++;
    if ({m1_txe, m1_err, grant} !== 4'b0000) begin
      n_errors++;
      $display("FAIL ew_release got %b exp 0000", {m1_txe, m1_err, grant});
    end
    ram_txe = 1'b1;
    tick();
    n_checks++;
    if ({grant, ram_txs} !== 3'b000) begin
      n_errors++;
      $display("FAIL ew_stale got %b exp 000", {grant, ram_txs});
    end
    ram_txe = 1'b0;
    tick();
    n_checks++;
    if ({grant, ram_txs} !== 3'b011) begin
      n_errors++;
      $display("FAIL ew_next got %b exp 011", {grant, ram_txs});
    end
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0; m0_txs = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_err_write();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
